// File: rtl/keccak_host_if_if.sv
// Host-side handshake bundle between the accelerator FSM and the Keccak host
// interface: message lanes in, digest lanes out, plus start/ready control.
interface keccak_host_if_if;
  logic        start;
  logic [63:0] din;
  logic        din_valid;
  logic        last_block;
  logic        buffer_full;
  logic        ready;
  logic [63:0] dout;
  logic        dout_valid;

  // Accelerator FSM side
  modport master (
    output start, din, din_valid, last_block,
    input  buffer_full, ready, dout, dout_valid
  );

  // Keccak host interface side
  modport slave (
    input  start, din, din_valid, last_block,
    output buffer_full, ready, dout, dout_valid
  );
endinterface

// File: rtl/keccak_host_if.sv
// Keccak host interface: buffers message lanes into a rate block, applies
// SHA-3 pad10*1, streams blocks lane-by-lane to the permutation core, then
// collects the digest and replays it to the accelerator FSM.
module keccak_host_if #(
  parameter int          RATE_LANES = 17,
  parameter int          OUT_LANES  = 4,
  parameter logic [7:0]  PAD_BYTE   = 8'h06
) (
  input  logic        clk,
  input  logic        rst_n,
  keccak_host_if_if.slave host,
  output logic [63:0] core_lane,
  output logic        core_lane_valid,
  input  logic        core_lane_ready,
  output logic        core_lane_last,
  output logic        core_final,
  input  logic        core_perm_done,
  input  logic [63:0] core_digest,
  input  logic        core_digest_valid
);

  localparam int CW   = $clog2(RATE_LANES + 1);
  localparam int BIW  = $clog2(RATE_LANES);
  localparam int OCW  = $clog2(OUT_LANES + 1);
  localparam int OIW  = (OUT_LANES > 1) ? $clog2(OUT_LANES) : 1;

  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_RATE = CW'(RATE_LANES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(RATE_LANES - 1);
  localparam logic [OCW-1:0] OC_ZERO  = {OCW{1'b0}};
  localparam logic [OCW-1:0] OC_ONE   = {{(OCW-1){1'b0}}, 1'b1};
  localparam logic [OCW-1:0] OC_FULL  = OCW'(OUT_LANES);
  localparam logic [OCW-1:0] OC_LAST  = OCW'(OUT_LANES - 1);
  localparam logic [63:0]    LANE_ZERO = {64{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_PAD     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_PERM    = 3'd4,
    ST_COLLECT = 3'd5,
    ST_OUTPUT  = 3'd6
  } state_t;

  state_t         state_r, state_nxt;
  logic [CW-1:0]  wr_cnt_r, wr_nxt;
  logic [CW-1:0]  rd_cnt_r, rd_nxt;
  logic [OCW-1:0] oc_r, oc_nxt;
  logic           final_r, final_nxt;
  logic           pad_pending_r, pad_nxt;
  logic [63:0]    lane_buf_r [RATE_LANES];
  logic [63:0]    lane_buf_nxt [RATE_LANES];
  logic [63:0]    obuf_r [OUT_LANES];
  logic [63:0]    obuf_nxt [OUT_LANES];

  logic           ready_r, ready_nxt;
  logic           buffer_full_r, buffer_full_nxt;
  logic [63:0]    dout_r, dout_nxt;
  logic           dout_valid_r, dout_valid_nxt;
  logic [63:0]    core_lane_r, core_lane_nxt;
  logic           core_lane_valid_r, core_lane_valid_nxt;
  logic           core_lane_last_r, core_lane_last_nxt;
  logic           core_final_r, core_final_nxt;

  assign host.ready       = ready_r;
  assign host.buffer_full = buffer_full_r;
  assign host.dout        = dout_r;
  assign host.dout_valid  = dout_valid_r;
  assign core_lane        = core_lane_r;
  assign core_lane_valid  = core_lane_valid_r;
  assign core_lane_last   = core_lane_last_r;
  assign core_final       = core_final_r;

  // Next-state, datapath updates and next values of the registered outputs
  always_comb begin
    state_nxt    = state_r;
    wr_nxt       = wr_cnt_r;
    rd_nxt       = rd_cnt_r;
    oc_nxt       = oc_r;
    final_nxt    = final_r;
    pad_nxt      = pad_pending_r;
    lane_buf_nxt = lane_buf_r;
    obuf_nxt     = obuf_r;

    case (state_r)
      ST_IDLE: begin
        if (host.start) begin
          state_nxt = ST_FILL;
          wr_nxt    = CNT_ZERO;
          rd_nxt    = CNT_ZERO;
          final_nxt = 1'b0;
          pad_nxt   = 1'b0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (host.din_valid) begin
          lane_buf_nxt[wr_cnt_r[BIW-1:0]] = host.din;
          wr_nxt = wr_cnt_r + CNT_ONE;
          if (wr_nxt == CNT_RATE) begin
            // A full block that also ends the message needs a separate pad block
            state_nxt = ST_DRAIN;
            pad_nxt   = host.last_block;
          end else if (host.last_block) begin
            state_nxt = ST_PAD;
          end else begin
            state_nxt = ST_FILL;
          end
        end else begin
          state_nxt = ST_FILL;
        end
      end
      ST_PAD: begin
        lane_buf_nxt[wr_cnt_r[BIW-1:0]][7:0] = lane_buf_r[wr_cnt_r[BIW-1:0]][7:0] ^ PAD_BYTE;
        lane_buf_nxt[RATE_LANES-1][63]       = 1'b1;
        final_nxt = 1'b1;
        state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (core_lane_ready) begin
          if (rd_cnt_r == CNT_LAST) begin
            for (int i = 0; i < RATE_LANES; i++) begin
              lane_buf_nxt[i] = LANE_ZERO;
            end
            wr_nxt    = CNT_ZERO;
            rd_nxt    = CNT_ZERO;
            state_nxt = ST_PERM;
          end else begin
            rd_nxt = rd_cnt_r + CNT_ONE;
          end
        end else begin
          rd_nxt = rd_cnt_r;
        end
      end
      ST_PERM: begin
        if (core_perm_done) begin
          if (final_r) begin
            state_nxt = ST_COLLECT;
            oc_nxt    = OC_ZERO;
          end else if (pad_pending_r) begin
            state_nxt = ST_PAD;
            pad_nxt   = 1'b0;
          end else begin
            state_nxt = ST_FILL;
          end
        end else begin
          state_nxt = ST_PERM;
        end
      end
      ST_COLLECT: begin
        if (core_digest_valid) begin
          obuf_nxt[oc_r[OIW-1:0]] = core_digest;
          oc_nxt = oc_r + OC_ONE;
          if (oc_nxt == OC_FULL) begin
            state_nxt = ST_OUTPUT;
            oc_nxt    = OC_ZERO;
          end else begin
            state_nxt = ST_COLLECT;
          end
        end else begin
          state_nxt = ST_COLLECT;
        end
      end
      ST_OUTPUT: begin
        if (oc_r == OC_LAST) begin
          state_nxt = ST_IDLE;
          oc_nxt    = OC_ZERO;
        end else begin
          oc_nxt = oc_r + OC_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    ready_nxt           = (state_nxt == ST_IDLE);
    buffer_full_nxt     = (state_nxt != ST_FILL);
    core_lane_valid_nxt = (state_nxt == ST_DRAIN);
    dout_valid_nxt      = (state_nxt == ST_OUTPUT);
    if (state_nxt == ST_DRAIN) begin
      core_lane_nxt      = lane_buf_nxt[rd_nxt[BIW-1:0]];
      core_lane_last_nxt = (rd_nxt == CNT_LAST);
      core_final_nxt     = final_nxt;
    end else begin
      core_lane_nxt      = LANE_ZERO;
      core_lane_last_nxt = 1'b0;
      core_final_nxt     = 1'b0;
    end
    if (state_nxt == ST_OUTPUT) begin
      dout_nxt = obuf_nxt[oc_nxt[OIW-1:0]];
    end else begin
      dout_nxt = dout_r;
    end
  end

  // State, buffers, counters and all outputs registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= ST_IDLE;
      wr_cnt_r          <= CNT_ZERO;
      rd_cnt_r          <= CNT_ZERO;
      oc_r              <= OC_ZERO;
      final_r           <= 1'b0;
      pad_pending_r     <= 1'b0;
      for (int i = 0; i < RATE_LANES; i++) begin
        lane_buf_r[i] <= LANE_ZERO;
      end
      for (int j = 0; j < OUT_LANES; j++) begin
        obuf_r[j] <= LANE_ZERO;
      end
      ready_r           <= 1'b1;
      buffer_full_r     <= 1'b1;
      dout_r            <= LANE_ZERO;
      dout_valid_r      <= 1'b0;
      core_lane_r       <= LANE_ZERO;
      core_lane_valid_r <= 1'b0;
      core_lane_last_r  <= 1'b0;
      core_final_r      <= 1'b0;
    end else begin
      state_r           <= state_nxt;
      wr_cnt_r          <= wr_nxt;
      rd_cnt_r          <= rd_nxt;
      oc_r              <= oc_nxt;
      final_r           <= final_nxt;
      pad_pending_r     <= pad_nxt;
      lane_buf_r        <= lane_buf_nxt;
      obuf_r            <= obuf_nxt;
      ready_r           <= ready_nxt;
      buffer_full_r     <= buffer_full_nxt;
      dout_r            <= dout_nxt;
      dout_valid_r      <= dout_valid_nxt;
      core_lane_r       <= core_lane_nxt;
      core_lane_valid_r <= core_lane_valid_nxt;
      core_lane_last_r  <= core_lane_last_nxt;
      core_final_r      <= core_final_nxt;
    end
  end

endmodule
